// File: rtl/lsu_dtcm_master.sv
// Load/store unit master for the data TCM: one operation in flight, issued as
// a command/response pair and retired through a writeback handshake.

`ifndef DTCM_ADDR_WIDTH
`define DTCM_ADDR_WIDTH 16
`endif
`ifndef DTCM_RAM_DW
`define DTCM_RAM_DW 32
`endif

module lsu_dtcm_master #(
   parameter int DTCM_ADDR_WIDTH = `DTCM_ADDR_WIDTH,
   parameter int DTCM_RAM_DW     = `DTCM_RAM_DW,
   parameter int DTCM_RAM_MW     = DTCM_RAM_DW / 8
) (
   input  logic                       clk,
   input  logic                       rst_n,

   input  logic                       exu_req_valid,
   output logic                       exu_req_ready,
   input  logic                       exu_req_read,
   input  logic [31:0]                exu_req_addr,
   input  logic [1:0]                 exu_req_size,
   input  logic                       exu_req_unsigned,
   input  logic [31:0]                exu_req_wdata,
   input  logic [4:0]                 exu_req_rd,

   output logic                       lsu_wb_valid,
   input  logic                       lsu_wb_ready,
   output logic                       lsu_wb_wen,
   output logic [4:0]                 lsu_wb_rd,
   output logic [31:0]                lsu_wb_data,
   output logic                       lsu_wb_err,

   output logic                       lsu2dtcm_cmd_valid,
   input  logic                       lsu2dtcm_cmd_ready,
   output logic                       lsu2dtcm_cmd_read,
   output logic [DTCM_ADDR_WIDTH-1:0] lsu2dtcm_cmd_addr,
   output logic [DTCM_RAM_MW-1:0]     lsu2dtcm_cmd_wmask,
   output logic [DTCM_RAM_DW-1:0]     lsu2dtcm_cmd_wdata,

   input  logic                       lsu2dtcm_rsp_valid,
   output logic                       lsu2dtcm_rsp_ready,
   input  logic [DTCM_RAM_DW-1:0]     lsu2dtcm_rsp_rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CMD  = 2'd1,
      S_RSP  = 2'd2,
      S_WB   = 2'd3
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic                       r_run;

   logic                       r_read;
   logic [1:0]                 r_size;
   logic                       r_unsigned;
   logic [1:0]                 r_lane;
   logic [DTCM_ADDR_WIDTH-1:0] r_cmd_addr;
   logic [DTCM_RAM_MW-1:0]     r_cmd_wmask;
   logic [DTCM_RAM_DW-1:0]     r_cmd_wdata;

   logic                       r_wb_wen;
   logic                       r_wb_err;
   logic [4:0]                 r_wb_rd;
   logic [31:0]                r_wb_data;

   logic                       w_accept;
   logic                       w_capture;
   logic                       w_misaligned;
   logic [DTCM_RAM_MW-1:0]     w_wmask;
   logic [DTCM_RAM_DW-1:0]     w_wdata;
   logic [31:0]                w_shift;
   logic [31:0]                w_load_data;
   logic                       w_unused;

   // Address bits above the DTCM window carry no meaning for this port.
   assign w_unused = ^exu_req_addr[31:DTCM_ADDR_WIDTH];

   // r_run keeps the request port closed while reset is asserted.
   assign exu_req_ready = (r_state == S_IDLE) && r_run;
   assign w_accept      = exu_req_valid && exu_req_ready;

   always_comb begin
      case (exu_req_size)
         SZ_BYTE: w_misaligned = 1'b0;
         SZ_HALF: w_misaligned = exu_req_addr[0];
         SZ_WORD: w_misaligned = |exu_req_addr[1:0];
         default: w_misaligned = 1'b1;
      endcase
   end

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      w_wmask = '1;
      w_wdata = exu_req_wdata;
      case (exu_req_size)
         SZ_BYTE: begin
            w_wmask = 4'b0001 << exu_req_addr[1:0];
            w_wdata = {4{exu_req_wdata[7:0]}};
         end
         SZ_HALF: begin
            w_wmask = 4'b0011 << exu_req_addr[1:0];
            w_wdata = {2{exu_req_wdata[15:0]}};
         end
         default: ;
      endcase
      if (exu_req_read) begin
         w_wmask = '0;
         w_wdata = '0;
      end
   end

   // Lane select by the byte offset, then extend to the requested size.
   always_comb begin
      w_shift     = lsu2dtcm_rsp_rdata >> {r_lane, 3'b000};
      w_load_data = w_shift;
      case (r_size)
         SZ_BYTE: w_load_data = {{24{~r_unsigned & w_shift[7]}},  w_shift[7:0]};
         SZ_HALF: w_load_data = {{16{~r_unsigned & w_shift[15]}}, w_shift[15:0]};
         default: ;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_nxt = w_misaligned ? S_WB : S_CMD;
         end
         S_CMD: begin
            if (lsu2dtcm_cmd_ready) begin
               if (lsu2dtcm_rsp_valid) begin
                  w_capture   = 1'b1;
                  w_state_nxt = S_WB;
               end else begin
                  w_state_nxt = S_RSP;
               end
            end
         end
         S_RSP: begin
            if (lsu2dtcm_rsp_valid) begin
               w_capture   = 1'b1;
               w_state_nxt = S_WB;
            end
         end
         S_WB: begin
            if (lsu_wb_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_run   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_run   <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_read      <= 1'b0;
         r_size      <= 2'b00;
         r_unsigned  <= 1'b0;
         r_lane      <= 2'b00;
         r_cmd_addr  <= '0;
         r_cmd_wmask <= '0;
         r_cmd_wdata <= '0;
      end else if (w_accept) begin
         r_read      <= exu_req_read;
         r_size      <= exu_req_size;
         r_unsigned  <= exu_req_unsigned;
         r_lane      <= exu_req_addr[1:0];
         r_cmd_addr  <= {exu_req_addr[DTCM_ADDR_WIDTH-1:2], 2'b00};
         r_cmd_wmask <= w_wmask;
         r_cmd_wdata <= w_wdata;
      end
   end

   // Faulting requests skip the DTCM; stores retire with zero data and no write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wb_wen  <= 1'b0;
         r_wb_err  <= 1'b0;
         r_wb_rd   <= 5'd0;
         r_wb_data <= 32'd0;
      end else if (w_accept) begin
         r_wb_wen  <= 1'b0;
         r_wb_err  <= w_misaligned;
         r_wb_rd   <= exu_req_rd;
         r_wb_data <= 32'd0;
      end else if (w_capture) begin
         r_wb_wen  <= r_read;
         r_wb_data <= r_read ? w_load_data : 32'd0;
      end
   end

   assign lsu2dtcm_cmd_valid = (r_state == S_CMD);
   assign lsu2dtcm_cmd_read  = r_read;
   assign lsu2dtcm_cmd_addr  = r_cmd_addr;
   assign lsu2dtcm_cmd_wmask = r_cmd_wmask;
   assign lsu2dtcm_cmd_wdata = r_cmd_wdata;
   assign lsu2dtcm_rsp_ready = (r_state == S_CMD) || (r_state == S_RSP);

   assign lsu_wb_valid = (r_state == S_WB);
   assign lsu_wb_wen   = r_wb_wen;
   assign lsu_wb_err   = r_wb_err;
   assign lsu_wb_rd    = r_wb_rd;
   assign lsu_wb_data  = r_wb_data;

endmodule
